gps_rmc_extract: RTL and testbench
==================================

// Module: gps_rmc_extract
// PURPOSE
//  Upstream of the lat/lon position stage. Parses the NMEA byte stream from the GPS UART receiver
//  and selects only RMC sentences ($GPRMC/$GNRMC) that have a valid fix. It then emits 10 ASCII
//  digit chars on jw_we/jw_data: 5 latitude digits first, then 5 longitude digits.
//  Each 5-digit group is minutes (2 digits) plus the first 3 minute decimals, e.g. "17.114" -> "17114".
// PARAMETERS
//  EMIT_GAP   2   idle cycles between consecutive jw_we pulses (ser2par latch margin)
//  MAX_LEN    82  max chars from '$' to end of sentence; exceeding this aborts the sentence
// PORTS
//  clk       in   1  system clock
//  rst       in   1  synchronous, active-high reset
//  rx_valid  in   1  one-cycle strobe, rx_data valid
//  rx_data   in   8  received byte
//  jw_we     out  1  one-cycle strobe per emitted char
//  jw_data   out  7  emitted ASCII digit, valid while jw_we=1
//  busy      out  1  emitter is sending a frame
//  frame_err out  1  one-cycle pulse when an RMC sentence is rejected
// BEHAVIOUR
//  Reset: all outputs are 0; parser is in IDLE; emitter is idle; capture buffer is cleared.
//  Parser FSM (advances only on rx_valid):
//   IDLE -> HDR on '$'; clear XOR and counters.
//   HDR: next 5 chars must be "GPRMC" or "GNRMC", else return to IDLE silently.
//   HDR -> FIELD on ','.
//   FIELD: ',' increments the field index and resets the char position. Field 2 must be 'A'.
//   Field 3 (lat "ddmm.mmmm"): capture positions 2,3,5,6,7. Position 4 must be '.'. Field length >= 8.
//   Field 5 (lon "dddmm.mmmm"): capture positions 3,4,6,7,8. Position 5 must be '.'. Field length >= 9.
//   FIELD -> CK_HI on '*' -> CK_LO -> COMMIT.
//  XOR covers every byte strictly between '$' and '*'. Checksum chars are uppercase hex.
//  Validity flag is cleared by any of:
//   non-digit in a captured position; wrong '.'; short field; status != 'A'; checksum mismatch.
//  COMMIT:
//   valid -> copy the 10-char buffer to the emit register and start the emitter.
//   invalid -> pulse frame_err.
//   Either way -> IDLE.
//  Abort to IDLE, with no frame_err: '$' in any state restarts HDR (same cycle);
//   byte with bit7=1; length > MAX_LEN; CR/LF before CK_LO.
//  Emitter: 10 chars, jw_we high 1 cycle each, then EMIT_GAP idle cycles.
//   busy is high from the commit cycle until the cycle after the 10th strobe.
//   First jw_we is 1 cycle after COMMIT. Frame length = 10*(EMIT_GAP+1) cycles.
//  Commit while busy: the new frame is dropped, frame_err pulses, and the current frame completes.
//   The parser never stalls.
//  rst mid-sentence or mid-frame: everything returns to reset values in the next cycle.
//   No partial frame resumes.
// CONFIGURATION
//  NMEA_CKSUM_EN defined: CK_HI/CK_LO are parsed and compared; a mismatch rejects the sentence.
//  NMEA_CKSUM_EN undefined: COMMIT happens on the ',' that ends field 6.
//   The '*' and checksum chars are ignored; the XOR logic is not built.
// STRUCTURE
//  Shared header nmea_defs.vh holds:
//   ASCII localparams ('$', ',', '*', '.', 'A', CR, LF); field indices (STATUS=2, LAT=3, LON=5);
//   capture position tables; FSM state encodings.
//  One sub-module, jw_char_emitter: 10x7-bit load, EMIT_GAP pacing counter, jw_we/jw_data/busy.
//  The parser FSM, counters, XOR and capture buffer stay in this module.
// TESTING
//  1 "$GPRMC,083559.00,A,4717.11437,N,00833.91522,E,0.004,77.52,091202,,,A*57\r\n"
//    -> jw_data sequence 1,7,1,1,4,3,3,9,1,5; 10 strobes spaced 3 cycles apart; frame_err=0.
//  2 Same sentence with status 'V'
//    -> no jw_we; one frame_err pulse.
//  3 Same sentence with checksum "*58", NMEA_CKSUM_EN defined
//    -> no jw_we; frame_err pulse.
//  3b Same sentence with checksum "*58", NMEA_CKSUM_EN undefined
//    -> the case-1 frame is emitted.
//  4 "$GPGGA,..." followed by a '$' injected mid-RMC, then a clean RMC
//    -> only the clean RMC emits; no frame_err for the aborted sentence.
//  5 Lat "47a7.11437"
//    -> rejected with frame_err. Back-to-back valid RMCs with a 0-gap byte stream:
//    2nd commit while busy -> dropped and frame_err; 1st frame emitted intact.
//  6 Assert rst during the 4th jw_we of case 1
//    -> next cycle jw_we=0 and busy=0; no further strobes; a fresh case-1 sentence emits normally.

Source files
------------

// File: rtl/gps_rmc_extract_pkg.sv
// Shared NMEA definitions for the RMC extractor: ASCII codes, field indices,
// capture position tables and parser state encodings.
package gps_rmc_extract_pkg;

  localparam int NUM_CHARS = 10;
  localparam int CAP_W     = 7;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  localparam logic [3:0] FLD_STATUS = 4'd2;
  localparam logic [3:0] FLD_LAT    = 4'd3;
  localparam logic [3:0] FLD_LON    = 4'd5;
  localparam logic [3:0] FLD_LAST   = 4'd6;

  localparam logic [6:0] LAT_DOT = 7'd4;
  localparam logic [6:0] LON_DOT = 7'd5;
  localparam logic [6:0] LAT_MIN = 7'd8;
  localparam logic [6:0] LON_MIN = 7'd9;

  typedef logic [NUM_CHARS-1:0][CAP_W-1:0] cap_buf_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_FIELD  = 3'd2,
    ST_CK_HI  = 3'd3,
    ST_CK_LO  = 3'd4,
    ST_COMMIT = 3'd5
  } parse_state_t;

  // {hit, slot}: lat minutes go to slots 0..4, lon minutes to slots 5..9
  function automatic logic [4:0] cap_slot(input logic [3:0] fld, input logic [6:0] pos);
    logic [4:0] r;
    r = 5'd0;
    if (fld == FLD_LAT) begin
      case (pos)
        7'd2: r = {1'b1, 4'd0};
        7'd3: r = {1'b1, 4'd1};
        7'd5: r = {1'b1, 4'd2};
        7'd6: r = {1'b1, 4'd3};
        7'd7: r = {1'b1, 4'd4};
        default: r = 5'd0;
      endcase
    end else if (fld == FLD_LON) begin
      case (pos)
        7'd3: r = {1'b1, 4'd5};
        7'd4: r = {1'b1, 4'd6};
        7'd6: r = {1'b1, 4'd7};
        7'd7: r = {1'b1, 4'd8};
        7'd8: r = {1'b1, 4'd9};
        default: r = 5'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Talker "GP" or "GN", sentence "RMC"
  function automatic logic hdr_ok(input logic [2:0] p, input logic [7:0] c);
    case (p)
      3'd0:    return c == 8'h47;
      3'd1:    return (c == 8'h50) || (c == 8'h4E);
      3'd2:    return c == 8'h52;
      3'd3:    return c == 8'h4D;
      3'd4:    return c == 8'h43;
      default: return 1'b0;
    endcase
  endfunction

  // {ok, nibble} for an uppercase hex digit
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (is_digit(c))                   return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

endpackage

// File: rtl/gps_rmc_extract_if.sv
// Byte-stream input and digit-stream output of the RMC extractor.
interface gps_rmc_extract_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       jw_we;
  logic [6:0] jw_data;
  logic       busy;
  logic       frame_err;

  modport master (output rx_valid, rx_data, input jw_we, jw_data, busy, frame_err);
  modport slave  (input rx_valid, rx_data, output jw_we, jw_data, busy, frame_err);
endinterface

// File: rtl/gps_rmc_extract_jw_char_emitter.sv
// Paced emitter: latches 10 captured chars and strobes them out one at a
// time with EMIT_GAP idle cycles between strobes.
module jw_char_emitter
  import gps_rmc_extract_pkg::*;
#(
  parameter int EMIT_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  cap_buf_t   data,
  output logic       jw_we,
  output logic [6:0] jw_data,
  output logic       active,
  output logic       busy
);

  localparam int GW = (EMIT_GAP < 2) ? 1 : $clog2(EMIT_GAP + 1);

  cap_buf_t        buf_q;
  logic [3:0]      idx;
  logic [GW-1:0]   gap;
  logic            last;

  assign last = (idx == 4'(NUM_CHARS - 1));
  // busy covers the load cycle itself, before active is registered
  assign busy = active | load;

  // Frame sequencer: strobe, gap count, next strobe, drop active after the last
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      idx     <= '0;
      gap     <= '0;
      active  <= 1'b0;
      jw_we   <= 1'b0;
      jw_data <= '0;
    end else begin
      jw_we   <= 1'b0;
      jw_data <= '0;
      if (load) begin
        buf_q   <= data;
        active  <= 1'b1;
        idx     <= '0;
        gap     <= '0;
        jw_we   <= 1'b1;
        jw_data <= data[0];
      end else if (active) begin
        if (jw_we) begin
          if (last) begin
            active <= 1'b0;
          end else if (EMIT_GAP == 0) begin
            idx     <= idx + 4'd1;
            jw_we   <= 1'b1;
            jw_data <= buf_q[idx + 4'd1];
          end else begin
            gap <= GW'(1);
          end
        end else if (gap >= GW'(EMIT_GAP)) begin
          idx     <= idx + 4'd1;
          jw_we   <= 1'b1;
          jw_data <= buf_q[idx + 4'd1];
        end else begin
          gap <= gap + GW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gps_rmc_extract.sv
// RMC sentence parser: filters $GPRMC/$GNRMC with a valid fix, captures the
// lat/lon minute digits and hands them to the paced char emitter.
// Build option: NMEA_CKSUM_EN enables the '*hh' checksum check; without it
// the sentence commits on the comma that closes field 6.
module gps_rmc_extract
  import gps_rmc_extract_pkg::*;
#(
  parameter int EMIT_GAP = 2,
  parameter int MAX_LEN  = 82
) (
  input  logic             clk,
  input  logic             rst,
  gps_rmc_extract_if.slave bus
);

  parse_state_t state, state_n;
  logic [2:0]   hdr_pos, hdr_n;
  logic [3:0]   fld, fld_n;
  logic [6:0]   pos, pos_n;
  logic [7:0]   len, len_n;
  logic         ok, ok_n;
  cap_buf_t     cap, cap_n;
  logic [4:0]   slot;
  logic         field_byte;
  logic [7:0]   c;
  logic         rv;
`ifdef NMEA_CKSUM_EN
  logic [7:0]   cks_q, cks_n;
  logic [4:0]   nib;
`endif

  logic       load, emit_active, emit_busy, emit_we;
  logic [6:0] emit_data;

  assign c  = bus.rx_data;
  assign rv = bus.rx_valid;

  // Parser state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hdr_pos <= '0;
      fld     <= '0;
      pos     <= '0;
      len     <= '0;
      ok      <= 1'b0;
      cap     <= '0;
`ifdef NMEA_CKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state   <= state_n;
      hdr_pos <= hdr_n;
      fld     <= fld_n;
      pos     <= pos_n;
      len     <= len_n;
      ok      <= ok_n;
      cap     <= cap_n;
`ifdef NMEA_CKSUM_EN
      cks_q   <= cks_n;
`endif
    end
  end

  // Next-state: header match, field walk, capture, validity and aborts
  always_comb begin
    state_n    = state;
    hdr_n      = hdr_pos;
    fld_n      = fld;
    pos_n      = pos;
    len_n      = len;
    ok_n       = ok;
    cap_n      = cap;
    field_byte = 1'b0;
    slot       = cap_slot(fld, pos);
`ifdef NMEA_CKSUM_EN
    cks_n      = cks_q;
    nib        = hex_nib(c);
`endif

    case (state)
      ST_IDLE: ;
      ST_COMMIT: state_n = ST_IDLE;
      default: begin
        if (rv && c != CH_DOLLAR) begin
          if (c[7] || c == CH_CR || c == CH_LF || len == 8'(MAX_LEN)) begin
            state_n = ST_IDLE;
          end else begin
            len_n = len + 8'd1;
            case (state)
              ST_HDR: begin
`ifdef NMEA_CKSUM_EN
                cks_n = cks_q ^ c;
`endif
                if (hdr_pos == 3'd5) begin
                  if (c == CH_COMMA) begin
                    state_n = ST_FIELD;
                    fld_n   = 4'd1;
                    pos_n   = '0;
                  end else begin
                    state_n = ST_IDLE;
                  end
                end else if (hdr_ok(hdr_pos, c)) begin
                  hdr_n = hdr_pos + 3'd1;
                end else begin
                  state_n = ST_IDLE;
                end
              end
              ST_FIELD: begin
`ifdef NMEA_CKSUM_EN
                if (c == CH_STAR) begin
                  state_n = ST_CK_HI;
                  // lat/lon fields never closed
                  if (fld <= FLD_LON) ok_n = 1'b0;
                end else begin
                  cks_n      = cks_q ^ c;
                  field_byte = 1'b1;
                end
`else
                field_byte = 1'b1;
`endif
              end
`ifdef NMEA_CKSUM_EN
              ST_CK_HI: begin
                if (!nib[4] || nib[3:0] != cks_q[7:4]) ok_n = 1'b0;
                state_n = ST_CK_LO;
              end
              ST_CK_LO: begin
                if (!nib[4] || nib[3:0] != cks_q[3:0]) ok_n = 1'b0;
                state_n = ST_COMMIT;
              end
`endif
              default: state_n = ST_IDLE;
            endcase

            if (field_byte) begin
              if (c == CH_COMMA) begin
                // pos now holds the length of the field being closed
                if (fld == FLD_STATUS && pos != 7'd1)   ok_n = 1'b0;
                if (fld == FLD_LAT    && pos < LAT_MIN) ok_n = 1'b0;
                if (fld == FLD_LON    && pos < LON_MIN) ok_n = 1'b0;
                if (fld != 4'hF) fld_n = fld + 4'd1;
                pos_n = '0;
`ifndef NMEA_CKSUM_EN
                if (fld == FLD_LAST) state_n = ST_COMMIT;
`endif
              end else begin
                if (fld == FLD_STATUS && (pos != 7'd0 || c != CH_A)) ok_n = 1'b0;
                if ((fld == FLD_LAT && pos == LAT_DOT) || (fld == FLD_LON && pos == LON_DOT))
                  if (c != CH_DOT) ok_n = 1'b0;
                if (slot[4]) begin
                  if (!is_digit(c)) ok_n = 1'b0;
                  cap_n[slot[3:0]] = c[6:0];
                end
                if (pos != 7'h7F) pos_n = pos + 7'd1;
              end
            end
          end
        end
      end
    endcase

    // '$' restarts the header from any state, including the commit cycle
    if (rv && c == CH_DOLLAR) begin
      state_n = ST_HDR;
      hdr_n   = '0;
      fld_n   = '0;
      pos_n   = '0;
      len_n   = 8'd1;
      ok_n    = 1'b1;
`ifdef NMEA_CKSUM_EN
      cks_n   = '0;
`endif
    end
  end

  // A valid commit is only accepted when the emitter is free; otherwise it is rejected
  assign load          = (state == ST_COMMIT) && ok && !emit_active;
  assign bus.frame_err = (state == ST_COMMIT) && !load;
  assign bus.jw_we     = emit_we;
  assign bus.jw_data   = emit_data;
  assign bus.busy      = emit_busy;

  jw_char_emitter #(.EMIT_GAP(EMIT_GAP)) u_emit (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (cap),
    .jw_we   (emit_we),
    .jw_data (emit_data),
    .active  (emit_active),
    .busy    (emit_busy)
  );

endmodule

// File: tb/tb_gps_rmc_extract.sv
// Directed bench for gps_rmc_extract. A second instance with a long EMIT_GAP
// shares the byte stream so a commit can land while its emitter is busy.
module tb_gps_rmc_extract;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  gps_rmc_extract_if bus ();
  gps_rmc_extract_if bus_s ();

  assign bus_s.rx_valid = bus.rx_valid;
  assign bus_s.rx_data  = bus.rx_data;

  gps_rmc_extract #(.EMIT_GAP(2), .MAX_LEN(82)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gps_rmc_extract #(.EMIT_GAP(9), .MAX_LEN(82)) u_dut_slow (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors, sampled on the falling edge
  int we_data[$];
  int we_cyc[$];
  int s_data[$];
  int n_err = 0;
  int s_err = 0;
  int busy_bad = 0;

  always @(negedge clk) begin
    if (bus.jw_we) begin
      we_data.push_back(int'(bus.jw_data));
      we_cyc.push_back(cyc);
      if (!bus.busy) busy_bad++;
    end
    if (bus.frame_err) n_err++;
    if (bus_s.jw_we) s_data.push_back(int'(bus_s.jw_data));
    if (bus_s.frame_err) s_err++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic string crlf();
    return $sformatf("%c%c", 8'd13, 8'd10);
  endfunction

  function automatic string mk(input string body);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < body.len(); i++) x ^= body[i];
    return {"$", body, "*", $sformatf("%02X", x), crlf()};
  endfunction

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[i];
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic clear_mon();
    we_data.delete();
    we_cyc.delete();
    s_data.delete();
    n_err = 0;
    s_err = 0;
    busy_bad = 0;
  endtask

  task automatic run_case(input string tag, input string stream, input string exp_d, input int exp_err);
    clear_mon();
    send_str(stream);
    idle(150);
    chk({tag, "_we_count"}, we_data.size(), exp_d.len());
    chk({tag, "_frame_err"}, n_err, exp_err);
    for (int i = 0; i < exp_d.len() && i < we_data.size(); i++)
      chk($sformatf("%s_char%0d", tag, i), we_data[i], int'(exp_d[i]));
    for (int i = 1; i < we_cyc.size(); i++)
      if (i % 10 != 0) chk($sformatf("%s_space%0d", tag, i), we_cyc[i] - we_cyc[i-1], 3);
    chk({tag, "_busy_at_we"}, busy_bad, 0);
    chk({tag, "_busy_idle"}, int'(bus.busy), 0);
  endtask

  string rmc_a, rmc_b, rmc_v, rmc_badlat, rmc_short, rmc_long, gga, pad;
  localparam string DIG_A = "1711433915";
  localparam string DIG_B = "3456776543";

  initial begin
    rmc_a      = "GPRMC,083559.00,A,4717.11437,N,00833.91522,E,0.004,77.52,091202,,,A";
    rmc_b      = "GPRMC,083559.00,A,1234.56789,N,09876.54321,E,0.004,77.52,091202,,,A";
    rmc_v      = "GPRMC,083559.00,V,4717.11437,N,00833.91522,E,0.004,77.52,091202,,,A";
    rmc_badlat = "GPRMC,083559.00,A,47a7.11437,N,00833.91522,E,0.004,77.52,091202,,,A";
    rmc_short  = "GNRMC,083559.00,A,4717.11,N,00833.91522,E,0.004,77.52,091202,,,A";
    gga        = "GPGGA,083559.00,4717.11437,N,00833.91522,E,1,08,1.0,0.0,M,0.0,M,,";
    pad = "";
    for (int i = 0; i < 40; i++) pad = {pad, "0"};
    rmc_long   = {"GPRMC,083559.00", pad, ",A,4717.11437,N,00833.91522,E,0.004,77.52,091202,,,A"};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_jw_we", int'(bus.jw_we), 0);
    chk("rst_jw_data", int'(bus.jw_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    rst = 1'b0;
    idle(3);

    run_case("c1_valid", mk(rmc_a), DIG_A, 0);
    run_case("c2_status_v", mk(rmc_v), "", 1);
`ifdef NMEA_CKSUM_EN
    run_case("c3_bad_cksum", {"$", rmc_a, "*58", crlf()}, "", 1);
`else
    run_case("c3b_cksum_off", {"$", rmc_a, "*58", crlf()}, DIG_A, 0);
`endif
    run_case("c4_abort", {mk(gga), "$GPRMC,083559.00,A,4717.1", mk(rmc_a)}, DIG_A, 0);
    run_case("c5_bad_digit", mk(rmc_badlat), "", 1);
    run_case("short_lat", mk(rmc_short), "", 1);
    run_case("too_long", mk(rmc_long), "", 0);

    // Back-to-back sentences: fast instance takes both, slow one drops the second
    run_case("c5_b2b", {mk(rmc_a), mk(rmc_b)}, {DIG_A, DIG_B}, 0);
    chk("c5_slow_we_count", s_data.size(), 10);
    chk("c5_slow_frame_err", s_err, 1);
    for (int i = 0; i < 10 && i < s_data.size(); i++)
      chk($sformatf("c5_slow_char%0d", i), s_data[i], int'(DIG_A[i]));

    // Reset during the 4th strobe
    clear_mon();
    fork
      send_str(mk(rmc_a));
      begin : rst_thr
        int  seen;
        bit  done;
        seen = 0;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
          @(negedge clk);
          if (bus.jw_we) begin
            seen++;
            if (seen == 4) begin
              rst  = 1'b1;
              done = 1'b1;
            end
          end
        end
        chk("c6_reached_4th_we", seen, 4);
        if (done) begin
          @(posedge clk); #1;
          chk("c6_we_after_rst", int'(bus.jw_we), 0);
          chk("c6_busy_after_rst", int'(bus.busy), 0);
          rst = 1'b0;
        end
      end
    join
    idle(150);
    chk("c6_no_more_we", we_data.size(), 4);
    chk("c6_frame_err", n_err, 0);
    run_case("c6_fresh", mk(rmc_a), DIG_A, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
